dec_rkey_loader: RTL and testbench
==================================

Name: dec_rkey_loader

Overview:
- Upstream feeder for the decryption round pipeline.
- Accepts round keys as 32-bit words over a valid/ready handshake and assembles each group of four words into a 128-bit round key.
- Broadcasts each key on the shared rkey/addr bus for one cycle. The round stage whose ADDRESS parameter matches addr captures it.
- Keys are supplied in decryption order. Key k (0-based arrival order) is tagged addr = k.

Parameters:
- NUM_RKEYS, 11: number of round keys loaded per key schedule; legal range 1..15.
- IDLE_ADDR, 4'hF: addr value driven when no key is being broadcast; no round stage uses it.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- key_word  input  32  round-key word; the first word of each key is bits [127:96], the fourth is [31:0].
- key_valid  input  1  key_word is valid.
- key_ready  output  1  block accepts key_word this cycle.
- reload  input  1  single-cycle pulse that restarts loading of a new key schedule.
- rkey  output  128  broadcast round key.
- addr  output  4  broadcast target address; IDLE_ADDR when idle.
- keys_loaded  output  1  all NUM_RKEYS keys have been broadcast.

Behaviour:
- Reset (rst high at clock edge):
  - state=LOAD, word_cnt=0, key_idx=0.
  - rkey=128'h0, addr=IDLE_ADDR, keys_loaded=0.
  - key_ready=0 while rst is high.
- key_ready = (state==LOAD) && !rst && !reload. This is the only combinational output.
- A handshake occurs when key_valid && key_ready.
- States:
  - LOAD: on each handshake, shift key_word into the 128-bit assembly register at slot word_cnt (MSB word first), then word_cnt++.
    - On the handshake with word_cnt==3: word_cnt wraps to 0 and the next state is BCAST.
    - key_valid low: hold; no state change.
  - BCAST (exactly 1 cycle, entered from the register update of the 4th word):
    - rkey = assembled key; addr = key_idx; key_ready=0.
    - Next edge: addr returns to IDLE_ADDR, while rkey holds its value until the next broadcast.
    - If key_idx==NUM_RKEYS-1: go to DONE and set keys_loaded=1.
    - Otherwise: key_idx++ and go to LOAD.
  - DONE: key_ready=0, keys_loaded=1, addr=IDLE_ADDR. Stays here until reload.
- Latency and throughput:
  - addr/rkey are valid in the cycle after the clock edge that accepts the 4th word.
  - Maximum throughput is 1 key per 5 cycles.
- Reload:
  - In LOAD: clears word_cnt and key_idx and discards the partial key. No handshake occurs that cycle because key_ready is 0.
  - In BCAST: the current broadcast still completes that cycle, then the block goes to LOAD with word_cnt, key_idx and keys_loaded cleared.
  - In DONE: goes to LOAD and clears keys_loaded the next cycle.
- rst mid-load or mid-broadcast: immediate return to the reset state. A broadcast in flight is cut short: addr=IDLE_ADDR after the edge.
- addr never takes values ≥ NUM_RKEYS other than IDLE_ADDR.

Decomposition:
- aes_pkg (shared): AES_NUM_RKEYS=11, AES_IDLE_ADDR=4'hF, AES_KEY_W=128, AES_WORD_W=32, and the loader state encoding (LOAD/BCAST/DONE).
- One natural sub-module: rkey_word_asm. It holds the 4-word assembly register and word_cnt, and outputs a full-key strobe. The FSM, key_idx and output registers stay in dec_rkey_loader.

Test Plan:
- Reset then idle: hold rst 3 cycles -> addr=4'hF, rkey=0, keys_loaded=0, key_ready=0 during rst and 1 after.
- Single key: words 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F on consecutive cycles -> next cycle rkey=128'h000102030405060708090A0B0C0D0E0F, addr=0 for exactly 1 cycle, key_ready=0 that cycle.
- Full schedule with random key_valid gaps, 44 words for 11 keys -> addr sequence 0..10, each on its own single cycle with the correct key. keys_loaded=1 after addr=10; key_ready stays 0 while key_valid is held high.
- Reload mid-key: 2 words, reload, then 4 new words -> broadcast contains only the new words, addr=0.
- Reload in DONE, then load key 0 again -> keys_loaded drops the cycle after reload; the next broadcast has addr=0.
- rst asserted during the BCAST cycle -> addr=4'hF and rkey=0 after the edge; a following load restarts at addr=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and the round-key loader state encoding.
// Used by the decryption key-feed logic and the round stages it addresses.
package aes_pkg;

   localparam int unsigned AES_NUM_RKEYS = 11;
   localparam logic [3:0]  AES_IDLE_ADDR = 4'hF;
   localparam int unsigned AES_KEY_W     = 128;
   localparam int unsigned AES_WORD_W    = 32;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_BCAST = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : aes_pkg

// File: rtl/rkey_word_asm.sv
// Collects 32-bit key words, MSB word first, into a 128-bit round key.
// Raises full in the cycle the fourth word is accepted, with key already complete.
module rkey_word_asm
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load,
   input  logic [AES_WORD_W-1:0] word,
   output logic [AES_KEY_W-1:0]  key,
   output logic                  full
);

   localparam int unsigned HELD_W = AES_KEY_W - AES_WORD_W;

   logic [1:0]        word_cnt;
   logic [HELD_W-1:0] held_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word_cnt <= 2'd0;
      end else if (load) begin
         word_cnt <= word_cnt + 2'd1;
      end
   end

   // NOTE: the data register has no reset; word_cnt alone decides which words are meaningful.
   always_ff @(posedge clk) begin
      if (load) begin
         held_q <= {held_q[HELD_W-AES_WORD_W-1:0], word};
      end
   end

   // The fourth word goes straight onto the key so it is ready at the accepting edge.
   assign key  = {held_q, word};
   assign full = load && (word_cnt == 2'd3);

endmodule : rkey_word_asm

// File: rtl/dec_rkey_loader.sv
// Feeds the decryption round pipeline: assembles round keys from words and
// broadcasts each for one cycle tagged with its arrival index on addr.
module dec_rkey_loader
   import aes_pkg::*;
#(
   parameter int unsigned NUM_RKEYS = AES_NUM_RKEYS,
   parameter logic [3:0]  IDLE_ADDR = AES_IDLE_ADDR
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AES_WORD_W-1:0] key_word,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic                  reload,
   output logic [AES_KEY_W-1:0]  rkey,
   output logic [3:0]            addr,
   output logic                  keys_loaded
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_RKEYS - 1);

   logic [1:0]           state;
   logic [3:0]           key_idx;
   logic                 handshake;
   logic                 key_full;
   logic [AES_KEY_W-1:0] key_asm;

   assign key_ready = (state == ST_LOAD) && !rst && !reload;
   assign handshake = key_valid && key_ready;

   rkey_word_asm u_word_asm (
      .clk  (clk),
      .rst  (rst),
      .clr  (reload),
      .load (handshake),
      .word (key_word),
      .key  (key_asm),
      .full (key_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_LOAD;
         key_idx     <= 4'd0;
         rkey        <= '0;
         addr        <= IDLE_ADDR;
         keys_loaded <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (reload) begin
                  key_idx <= 4'd0;
               end else if (key_full) begin
                  rkey  <= key_asm;
                  addr  <= key_idx;
                  state <= ST_BCAST;
               end
            end
            ST_BCAST: begin
               // rkey stays put after the broadcast; only addr marks the valid cycle.
               addr <= IDLE_ADDR;
               if (reload) begin
                  key_idx     <= 4'd0;
                  keys_loaded <= 1'b0;
                  state       <= ST_LOAD;
               end else if (key_idx == LAST_IDX) begin
                  keys_loaded <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  key_idx <= key_idx + 4'd1;
                  state   <= ST_LOAD;
               end
            end
            ST_DONE: begin
               if (reload) begin
                  key_idx     <= 4'd0;
                  keys_loaded <= 1'b0;
                  state       <= ST_LOAD;
               end
            end
            default: begin
               addr  <= IDLE_ADDR;
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule : dec_rkey_loader

// File: tb/tb_dec_rkey_loader.sv
// Directed bench for dec_rkey_loader: reset, single key, full schedule with
// gaps, reload in each state and reset during a broadcast.
module tb_dec_rkey_loader;

   logic         clk;
   logic         rst;
   logic [31:0]  key_word;
   logic         key_valid;
   logic         key_ready;
   logic         reload;
   logic [127:0] rkey;
   logic [3:0]   addr;
   logic         keys_loaded;

   int errors = 0;
   int checks = 0;

   dec_rkey_loader dut (
      .clk         (clk),
      .rst         (rst),
      .key_word    (key_word),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .reload      (reload),
      .rkey        (rkey),
      .addr        (addr),
      .keys_loaded (keys_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_of(input int k, input int j);
      return {8'(k), 8'(j), 8'(8'hC0 + k), 8'(8'h30 + j)};
   endfunction

   function automatic logic [127:0] key_of(input int k);
      return {word_of(k, 0), word_of(k, 1), word_of(k, 2), word_of(k, 3)};
   endfunction

   // Advance one clock; the bench always acts 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [127:0] k);
      for (int j = 0; j < 4; j++) begin
         key_valid = 1'b1;
         key_word  = k[127 - 32*j -: 32];
         step();
      end
      key_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++; if (addr !== 4'hF) begin errors++; $display("FAIL reset_addr: got %h want %h", addr, 4'hF); end
      checks++; if (rkey !== 128'h0) begin errors++; $display("FAIL reset_rkey: got %h want 0", rkey); end
      checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b want 0", keys_loaded); end
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", key_ready); end
      rst = 1'b0;
      #1;
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", key_ready); end
   endtask

   task automatic test_single_key();
      logic [127:0] exp_key;
      exp_key = 128'h000102030405060708090A0B0C0D0E0F;
      send_key(exp_key);
      #1;
      checks++; if (rkey !== exp_key) begin errors++; $display("FAIL single_rkey: got %h want %h", rkey, exp_key); end
      checks++; if (addr !== 4'd0) begin errors++; $display("FAIL single_addr: got %h want 0", addr); end
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL single_ready_bcast: got %b want 0", key_ready); end
      step();
      checks++; if (addr !== 4'hF) begin errors++; $display("FAIL single_addr_idle: got %h want F", addr); end
      checks++; if (rkey !== exp_key) begin errors++; $display("FAIL single_rkey_hold: got %h want %h", rkey, exp_key); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b want 1", key_ready); end
   endtask

   task automatic test_full_schedule();
      apply_reset();
      for (int k = 0; k < 11; k++) begin
         for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(0, 2)) begin
               key_valid = 1'b0;
               step();
            end
            key_valid = 1'b1;
            key_word  = word_of(k, j);
            step();
         end
         // Broadcast cycle: hold a word on the bus to show it is not taken.
         key_valid = 1'b1;
         key_word  = (k < 10) ? word_of(k + 1, 0) : 32'hDEADBEEF;
         #1;
         checks++; if (addr !== 4'(k)) begin errors++; $display("FAIL sched_addr k=%0d: got %h want %h", k, addr, 4'(k)); end
         checks++; if (rkey !== key_of(k)) begin errors++; $display("FAIL sched_rkey k=%0d: got %h want %h", k, rkey, key_of(k)); end
         checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL sched_ready_bcast k=%0d: got %b want 0", k, key_ready); end
         step();
         checks++; if (addr !== 4'hF) begin errors++; $display("FAIL sched_addr_idle k=%0d: got %h want F", k, addr); end
         checks++; if (keys_loaded !== (k == 10)) begin errors++; $display("FAIL sched_loaded k=%0d: got %b want %b", k, keys_loaded, (k == 10)); end
      end
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b want 0", key_ready); end
      repeat (3) step();
      checks++; if (addr !== 4'hF || keys_loaded !== 1'b1) begin errors++; $display("FAIL done_hold: got addr=%h loaded=%b want F/1", addr, keys_loaded); end
      key_valid = 1'b0;
   endtask

   task automatic test_reload_done();
      reload = 1'b1;
      #1;
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL rld_done_ready: got %b want 0", key_ready); end
      step();
      reload = 1'b0;
      #1;
      checks++; if (keys_loaded !== 1'b0) begin errors++; $display("FAIL rld_done_loaded: got %b want 0", keys_loaded); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rld_done_ready_after: got %b want 1", key_ready); end
      send_key(key_of(3));
      checks++; if (addr !== 4'd0) begin errors++; $display("FAIL rld_done_addr: got %h want 0", addr); end
      checks++; if (rkey !== key_of(3)) begin errors++; $display("FAIL rld_done_rkey: got %h want %h", rkey, key_of(3)); end
      step();
   endtask

   task automatic test_reload_mid_key();
      logic [127:0] new_key;
      new_key = 128'h11112222_33334444_55556666_77778888;
      key_valid = 1'b1;
      key_word  = 32'hAAAA0000;
      step();
      key_word  = 32'hAAAA0001;
      step();
      key_word  = 32'hAAAA0002;
      reload    = 1'b1;
      #1;
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL rld_mid_ready: got %b want 0", key_ready); end
      step();
      reload = 1'b0;
      send_key(new_key);
      checks++; if (rkey !== new_key) begin errors++; $display("FAIL rld_mid_rkey: got %h want %h", rkey, new_key); end
      checks++; if (addr !== 4'd0) begin errors++; $display("FAIL rld_mid_addr: got %h want 0", addr); end
      step();
   endtask

   task automatic test_reload_bcast();
      // One key is already out, so this one is tagged 1.
      send_key(key_of(5));
      reload = 1'b1;
      #1;
      checks++; if (addr !== 4'd1) begin errors++; $display("FAIL rld_bc_addr: got %h want 1", addr); end
      checks++; if (rkey !== key_of(5)) begin errors++; $display("FAIL rld_bc_rkey: got %h want %h", rkey, key_of(5)); end
      step();
      reload = 1'b0;
      #1;
      checks++; if (addr !== 4'hF || key_ready !== 1'b1) begin errors++; $display("FAIL rld_bc_after: got addr=%h ready=%b want F/1", addr, key_ready); end
      send_key(key_of(6));
      checks++; if (addr !== 4'd0) begin errors++; $display("FAIL rld_bc_restart_addr: got %h want 0", addr); end
      step();
   endtask

   task automatic test_rst_bcast();
      send_key(key_of(7));
      checks++; if (addr !== 4'd1) begin errors++; $display("FAIL rst_bc_pre_addr: got %h want 1", addr); end
      rst = 1'b1;
      step();
      checks++; if (addr !== 4'hF) begin errors++; $display("FAIL rst_bc_addr: got %h want F", addr); end
      checks++; if (rkey !== 128'h0) begin errors++; $display("FAIL rst_bc_rkey: got %h want 0", rkey); end
      rst = 1'b0;
      #1;
      send_key(key_of(8));
      checks++; if (addr !== 4'd0) begin errors++; $display("FAIL rst_bc_restart_addr: got %h want 0", addr); end
      checks++; if (rkey !== key_of(8)) begin errors++; $display("FAIL rst_bc_restart_rkey: got %h want %h", rkey, key_of(8)); end
      step();
   endtask

   initial begin
      rst       = 1'b1;
      key_word  = 32'h0;
      key_valid = 1'b0;
      reload    = 1'b0;
      test_reset();
      test_single_key();
      test_full_schedule();
      test_reload_done();
      test_reload_mid_key();
      test_reload_bcast();
      test_rst_bcast();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dec_rkey_loader
